// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB receive packet controller.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        SEND,
        WAIT,
        DRAIN,
        DRAIN_RD,
        DONE
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;

    // A PID byte carries its 4-bit code followed by the one's complement of that code.
    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_packet_ctrl.sv
// Drains the receiver FIFO one byte at a time, validates the PID byte, forwards the payload
// downstream and reports each packet's PID, length and error status when the packet ends.
module usb_rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_LEN = 64,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_empty,
    input  logic             rx_rcving,
    input  logic             rx_error,
    input  logic [7:0]       rx_data,
    output logic             rx_r_enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sop,
    output logic [3:0]       pkt_pid,
    output logic [LEN_W-1:0] pkt_len,
    output logic             pkt_done,
    output logic             pkt_err,
    output state_t           dbg_state
);

    // Handshake: a byte moves on any rising edge where out_valid && out_ready. Once raised,
    // out_valid stays high and out_data/out_sop stay frozen until that edge.

    state_t state;
    logic   err;
    logic   first;
    logic   err_set;

    assign dbg_state = state;

    always_comb begin
        err_set = 1'b0;
        if (rx_error && (state == RD || state == CAP || state == SEND || state == WAIT))
            err_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            err         <= 1'b0;
            first       <= 1'b0;
            rx_r_enable <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            pkt_pid     <= '0;
            pkt_len     <= '0;
            pkt_done    <= 1'b0;
            pkt_err     <= 1'b0;
        end else begin
            rx_r_enable <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_err     <= 1'b0;
            if (err_set)
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        pkt_len     <= '0;
                        err         <= 1'b0;
                        first       <= 1'b1;
                        rx_r_enable <= 1'b1;
                        state       <= RD;
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (first) begin
                        if (pid_ok(rx_data)) begin
                            pkt_pid <= rx_data[3:0];
                            first   <= 1'b0;
                            state   <= WAIT;
                        end else begin
                            err   <= 1'b1;
                            state <= DRAIN;
                        end
                    end else if (pkt_len == LEN_W'(MAX_LEN)) begin
                        // Overflow byte is dropped; pkt_len stays pinned at MAX_LEN.
                        err   <= 1'b1;
                        state <= DRAIN;
                    end else begin
                        out_data  <= rx_data;
                        out_sop   <= (pkt_len == '0);
                        out_valid <= 1'b1;
                        pkt_len   <= pkt_len + LEN_W'(1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_sop   <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (err) begin
                        state <= DRAIN;
                    end else if (!rx_empty) begin
                        rx_r_enable <= 1'b1;
                        state       <= RD;
                    end else if (!rx_rcving) begin
                        pkt_done <= 1'b1;
                        pkt_err  <= err | err_set;
                        state    <= DONE;
                    end
                end
                DRAIN: begin
                    if (!rx_empty) begin
                        rx_r_enable <= 1'b1;
                        state       <= DRAIN_RD;
                    end else if (!rx_rcving) begin
                        pkt_done <= 1'b1;
                        pkt_err  <= err;
                        state    <= DONE;
                    end
                end
                DRAIN_RD: state <= DRAIN;
                DONE:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl: a small FIFO model feeds packets, and a negedge
// monitor checks forwarded bytes and packet reports against queues of expected results.
module tb_usb_rx_packet_ctrl;
    import usb_rx_pkg::*;

    localparam int MAX_LEN = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             tb_clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_empty;
    logic             rx_rcving = 1'b0;
    logic             rx_error = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_r_enable;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_sop;
    logic [3:0]       pkt_pid;
    logic [LEN_W-1:0] pkt_len;
    logic             pkt_done;
    logic             pkt_err;
    state_t           dbg_state;

    usb_rx_packet_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk(tb_clk), .rst(rst), .rx_empty(rx_empty), .rx_rcving(rx_rcving),
        .rx_error(rx_error), .rx_data(rx_data), .rx_r_enable(rx_r_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .pkt_pid(pkt_pid), .pkt_len(pkt_len),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .dbg_state(dbg_state)
    );

    always #5 tb_clk = ~tb_clk;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [7:0] exp_done_q[$];

    // Receiver FIFO model: the initial block owns wr_ptr, the read process owns rd_ptr.
    logic [7:0] fifo_mem[16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_count = 0;
    int rd_base = 0;

    assign rx_empty = (wr_ptr == rd_ptr);

    always @(negedge tb_clk) begin
        if (rx_r_enable) begin
            rd_count++;
            if (rd_ptr != wr_ptr) begin
                rx_data = fifo_mem[rd_ptr % 16];
                rd_ptr++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       stall_sop = 1'b0;

    always @(negedge tb_clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("hold", {22'd0, out_valid, out_sop, out_data, rx_r_enable},
                      {22'd0, 1'b1, stall_sop, stall_data, 1'b0});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_byte", {23'd0, out_sop, out_data}, 32'h1ff);
                else
                    check("byte", {23'd0, out_sop, out_data}, {23'd0, exp_q.pop_front()});
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_sop  = out_sop;
            if (pkt_done) begin
                if (exp_done_q.size() == 0)
                    check("unexpected_done", {24'd0, pkt_err, pkt_len, pkt_pid}, 32'h1ff);
                else
                    check("done", {24'd0, pkt_err, pkt_len, pkt_pid}, {24'd0, exp_done_q.pop_front()});
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr++;
    endtask

    task automatic expect_out(input logic sop, input logic [7:0] d);
        exp_q.push_back({sop, d});
    endtask

    task automatic expect_done(input logic err, input logic [LEN_W-1:0] len, input logic [3:0] pid);
        exp_done_q.push_back({err, len, pid});
    endtask

    task automatic begin_pkt();
        @(negedge tb_clk);
        rd_base   = rd_count;
        rx_rcving = 1'b1;
    endtask

    task automatic wait_out(input logic [7:0] d, input string name);
        int n = 0;
        while (!(out_valid && out_data == d) && n < 100) begin
            @(posedge tb_clk); #1;
            n++;
        end
        check(name, (n < 100), 1);
    endtask

    task automatic finish_pkt(input int exp_reads, input string name);
        int n = 0;
        rx_rcving = 1'b0;
        while (!pkt_done && n < 200) begin
            @(posedge tb_clk); #1;
            n++;
        end
        check({name, "_done_seen"}, (n < 200), 1);
        check({name, "_reads"}, rd_count - rd_base, exp_reads);
        check({name, "_fifo_empty"}, rx_empty, 1);
        repeat (3) @(posedge tb_clk);
        #1;
    endtask

    task automatic clean_packet(input string name);
        begin_pkt();
        push_byte(8'hC3); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        expect_out(1'b1, 8'h11); expect_out(1'b0, 8'h22); expect_out(1'b0, 8'h33);
        expect_done(1'b0, 3, 4'h3);
    endtask

    initial begin
        int rd_before;

        repeat (3) @(posedge tb_clk);
        #1;
        check("rst_outputs", {out_valid, rx_r_enable, pkt_done, pkt_err, out_sop}, 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_pid_len", {pkt_pid, pkt_len}, 0);
        rst = 1'b0;

        // Basic packet, including read-strobe latency and PID capture timing.
        clean_packet("basic");
        @(posedge tb_clk); #1;
        check("lat_rd_en", rx_r_enable, 1);
        check("lat_rd_state", dbg_state, RD);
        @(posedge tb_clk); #1;
        check("lat_rd_single", rx_r_enable, 0);
        @(posedge tb_clk); #1;
        check("lat_pid", pkt_pid, 4'h3);
        repeat (40) @(posedge tb_clk);
        #1;
        finish_pkt(4, "basic");
        check("held_len_pid", {pkt_pid, pkt_len}, {4'h3, 3'd3});

        // Same packet with the downstream stalling for 10 cycles on the second byte.
        clean_packet("stall");
        wait_out(8'h22, "stall_seen");
        out_ready = 1'b0;
        rd_before = rd_count;
        repeat (10) @(posedge tb_clk);
        #1;
        check("stall_no_reads", rd_count - rd_before, 0);
        out_ready = 1'b1;
        finish_pkt(4, "stall");

        // Bad PID: whole packet drained, nothing forwarded, previous PID kept.
        begin_pkt();
        push_byte(8'hC4); push_byte(8'h01); push_byte(8'h02);
        expect_done(1'b1, 0, 4'h3);
        finish_pkt(3, "badpid");

        // Receive error while the first payload byte is being handed over.
        begin_pkt();
        push_byte(8'h4B); push_byte(8'hAA); push_byte(8'hBB);
        expect_out(1'b1, 8'hAA);
        expect_done(1'b1, 1, 4'hB);
        wait_out(8'hAA, "rxerr_seen");
        rx_error = 1'b1;
        @(posedge tb_clk); #1;
        rx_error = 1'b0;
        finish_pkt(3, "rxerr");

        // Length overflow at MAX_LEN, then a PID-only packet.
        begin_pkt();
        push_byte(8'hD2);
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        expect_out(1'b1, 8'h01); expect_out(1'b0, 8'h02);
        expect_out(1'b0, 8'h03); expect_out(1'b0, 8'h04);
        expect_done(1'b1, 4, 4'h2);
        finish_pkt(6, "overflow");

        begin_pkt();
        push_byte(8'hD2);
        expect_done(1'b0, 0, 4'h2);
        finish_pkt(1, "pidonly");

        // Reset while a byte is waiting in SEND; the packet is abandoned silently.
        out_ready = 1'b0;
        begin_pkt();
        push_byte(8'hD2); push_byte(8'h55);
        wait_out(8'h55, "rst_send_seen");
        check("rst_in_send", dbg_state, SEND);
        rx_rcving = 1'b0;
        rst = 1'b1;
        @(posedge tb_clk); #1;
        check("rst_mid_outputs", {out_valid, rx_r_enable, pkt_done}, 0);
        check("rst_mid_state", dbg_state, IDLE);
        check("rst_mid_pid_len", {pkt_pid, pkt_len}, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        clean_packet("after_rst");
        finish_pkt(4, "after_rst");

        check("byte_queue_empty", exp_q.size(), 0);
        check("done_queue_empty", exp_done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_rx_packet_ctrl.md
Name: usb_rx_packet_ctrl

Overview:
- Read-side controller for the USB receiver's RX FIFO.
- Issues single-cycle read strobes whenever the FIFO is non-empty and checks the leading PID byte.
- Forwards payload bytes to a downstream consumer over a valid/ready handshake.
- Reports packet completion with PID, payload length and error status. On a receive error it drains and discards the remainder of the packet.

Parameters:
MAX_LEN, 64, maximum payload bytes per packet (PID byte excluded); one more byte is a length error.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
rx_empty  in  1  receiver FIFO empty
rx_rcving  in  1  receiver currently inside a packet (SYNC seen, EOP not yet)
rx_error  in  1  receiver error flag (bit-stuff/EOP/framing)
rx_data  in  8  FIFO read data, valid the cycle after rx_r_enable
rx_r_enable  out  1  FIFO read strobe, one cycle per byte
out_valid  out  1  payload byte available
out_ready  in  1  downstream accepts byte
out_data  out  8  payload byte
out_sop  out  1  with out_valid: first payload byte of packet
pkt_pid  out  4  PID of current/last packet (low nibble of PID byte)
pkt_len  out  LEN_W  payload bytes accepted so far; LEN_W = $clog2(MAX_LEN+1)
pkt_done  out  1  one-cycle pulse at packet end
pkt_err  out  1  valid with pkt_done: packet was bad

Behaviour:
- Reset (sync, rst=1 at rising edge): state IDLE; all outputs 0; pkt_pid=0; pkt_len=0; internal err flag cleared. Reset mid-packet abandons the packet with no pkt_done. The receiver FIFO is not touched.
- IDLE: pkt_len held from last packet. On !rx_empty: clear pkt_len and err, set first=1, go to RD.
- RD: rx_r_enable=1 (only here and in DRAIN_RD), then go to CAP.
- CAP: sample rx_data.
  - If first: PID valid iff rx_data[7:4] == ~rx_data[3:0]. Valid → pkt_pid=rx_data[3:0], first=0, go to WAIT. Invalid → err=1, go to DRAIN.
  - Else if pkt_len == MAX_LEN → err=1, go to DRAIN.
  - Else hold_data=rx_data, pkt_len+1, go to SEND.
- SEND: out_valid=1, out_data=hold_data, out_sop=(pkt_len==1).
  - out_valid, out_data and out_sop are held stable until out_ready=1; valid is never withdrawn.
  - On handshake go to WAIT.
- WAIT, priority order:
  - err flag set → DRAIN
  - else !rx_empty → RD
  - else !rx_rcving → DONE
  - else stay in WAIT
- rx_error sampled high in RD/CAP/SEND/WAIT sets sticky err. Remaining transitions still complete (an in-flight SEND finishes its handshake); WAIT then diverts to DRAIN.
- DRAIN: no output bytes.
  - !rx_empty → DRAIN_RD (rx_r_enable=1, data discarded), then return to DRAIN after one cycle.
  - Else !rx_rcving → DONE.
- DONE: pkt_done=1 for one cycle, pkt_err=err; pkt_pid and pkt_len valid this cycle and held until next packet starts; then go to IDLE.
- PID-only packet: legal; pkt_done with pkt_len=0, pkt_err=0.
- Latency: !rx_empty seen in IDLE at cycle t → rx_r_enable at t+1 → PID captured t+2. Steady state is 4 cycles/byte with out_ready=1, well within 64 clk/byte line rate.
- pkt_len never exceeds MAX_LEN; the overflow byte is discarded, not forwarded.

Decomposition:
- Package usb_rx_pkg holds:
  - state enum (IDLE, RD, CAP, SEND, WAIT, DRAIN, DRAIN_RD, DONE)
  - function pid_ok(input [7:0]) returning the nibble-complement check
  - PID code constants (OUT=4'h1, IN=4'h9, DATA0=4'h3, DATA1=4'hB, ACK=4'h2)
- No sub-module. Single FSM plus datapath registers.

Test Plan:
- PID 8'hC3 + payload 8'h11,8'h22,8'h33, out_ready=1, then rx_rcving falls → three handshakes, sop on 8'h11 only; pkt_done with pkt_pid=3, pkt_len=3, pkt_err=0.
- Same packet with out_ready low 10 cycles on byte 2 → out_valid/out_data=8'h22 held stable 10 cycles; no extra rx_r_enable meanwhile; result identical.
- Bad PID 8'hC4 + 2 bytes → no out_valid; 3 rx_r_enable total; FIFO empty at end; pkt_done with pkt_err=1, pkt_len=0.
- rx_error pulses after 1st payload byte (PID 8'h4B, bytes 8'hAA,8'hBB) → 8'hAA forwarded, 8'hBB drained without out_valid; pkt_done with pkt_err=1, pkt_len=1.
- MAX_LEN=4, PID 8'hD2 + 5 bytes → 4 forwarded, 5th drained; pkt_err=1, pkt_len=4. PID-only 8'hD2 → pkt_len=0, pkt_err=0.
- rst asserted while in SEND → next cycle out_valid=0, rx_r_enable=0, pkt_done=0, state IDLE; following clean packet processes normally.
